// File: rtl/fp_mult_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fp_mult_issue_ctrl
//
// Issue/collect controller wrapped around a fixed-latency floating-point
// multiplier pipeline that has neither a valid nor a stall input. Operand
// pairs are registered onto the multiplier inputs. A valid/tag shift pipe
// follows each issue through the multiplier, and every result is captured
// into a result FIFO that is presented downstream with classification flags.
//
// Handshakes (both sides): a transfer happens at a rising edge where valid and
// ready are both high. The producer holds valid and its payload until that
// edge. The controller's ready/valid outputs come straight from registers and
// never depend on the partner's valid/ready in the same cycle.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake; in_a, in_b (fp32), in_tag
//   mul_a, mul_b         registered operands driven into the multiplier
//   mul_out              multiplier result, LATENCY edges after mul_a/mul_b load
//   out_valid/out_ready  result handshake; out_data (fp32), out_tag
//   out_is_nan/inf/zero  classification of out_data
//   busy                 operations in flight or results waiting
// -----------------------------------------------------------------------------
module fp_mult_issue_ctrl #(
  parameter int LATENCY    = 14,
  parameter int FIFO_DEPTH = 16,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [31:0]      mul_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_is_nan,
  output logic             out_is_inf,
  output logic             out_is_zero,
  output logic             busy
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;

  // Held low through reset and for the first edge after release, so nothing
  // is accepted before the pipe and FIFO state is known to be clean.
  logic               ready_en;
  logic [CNT_W-1:0]   credit;

  logic [LATENCY-1:0] pipe_vld;
  logic [TAG_W-1:0]   pipe_tag [LATENCY];

  logic [31:0]        data_mem [FIFO_DEPTH];
  logic [TAG_W-1:0]   tag_mem  [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   count;

  logic accept;
  logic pop;
  logic fifo_wr;

  assign in_ready  = ready_en & (credit != '0);
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // The tail of the valid pipe lines up with the multiplier output word.
  assign fifo_wr   = pipe_vld[LATENCY-1];

  // ---------------------------------------------------------------------------
  // Operand registers and reset-release flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Credit: slots not yet claimed by an in-flight op or a stored result.
  // Issuing only against a credit means a capture can never meet a full FIFO.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= CNT_W'(FIFO_DEPTH);
    end else if (accept && !pop) begin
      credit <= credit - CNT_W'(1);
    end else if (pop && !accept) begin
      credit <= credit + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight tracking. Only the valid bits are reset: clearing them drops
  // every in-flight op, so those results are never written to the FIFO.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld <= {pipe_vld[LATENCY-2:0], accept};
    end
  end

  always_ff @(posedge clk) begin
    pipe_tag[0] <= in_tag;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO. The head is read combinationally from storage, so a word
  // written into an empty FIFO appears on out_data the cycle after the write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      data_mem[wr_ptr] <= mul_out;
      tag_mem[wr_ptr]  <= pipe_tag[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (fifo_wr && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !fifo_wr) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign out_data = data_mem[rd_ptr];
  assign out_tag  = tag_mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // Classification and status
  // ---------------------------------------------------------------------------
  assign out_is_nan  = (&out_data[30:23]) & (|out_data[22:0]);
  assign out_is_inf  = (&out_data[30:23]) & ~(|out_data[22:0]);
  assign out_is_zero = ~(|out_data[30:23]);

  assign busy = (pipe_vld != '0) | (count != '0);

  // A capture into a full FIFO that is not being popped would drop a result.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_wr && (count == CNT_W'(FIFO_DEPTH)) && !pop));

endmodule

// File: tb/tb_fp_mult_issue_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for fp_mult_issue_ctrl. A behavioural stand-in for the multiplier
// feeds mul_out. A queue-based reference model predicts in_ready, out_valid,
// busy, the operand registers and the FIFO head each cycle.
// -----------------------------------------------------------------------------
module tb_fp_mult_issue_ctrl;

  localparam int LATENCY    = 14;
  localparam int FIFO_DEPTH = 16;
  localparam int TAG_W      = 4;
  localparam int EW         = TAG_W + 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic [31:0]      mul_out;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_is_nan;
  logic             out_is_inf;
  logic             out_is_zero;
  logic             busy;

  fp_mult_issue_ctrl #(
    .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .out_is_nan(out_is_nan), .out_is_inf(out_is_inf), .out_is_zero(out_is_zero),
    .busy(busy)
  );

  // ---------------------------------------------------------------------------
  // Behavioural fp32 multiply (truncating; inf*0 and NaN inputs give 0x7FFFFFFF)
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    logic [47:0] p;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FFF_FFFF;
    if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7FFF_FFFF;
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'd0};
    if (ea == 0 || eb == 0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = ea + eb - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], m};
  endfunction

  // Multiplier stand-in: mul_a/mul_b loaded at edge E give the product on
  // mul_out just before edge E+LATENCY.
  logic [31:0] stub [LATENCY-1];
  always @(posedge clk) begin
    stub[0] <= fp_mul(mul_a, mul_b);
    for (int i = 1; i < LATENCY - 1; i++) stub[i] <= stub[i-1];
  end
  assign mul_out = stub[LATENCY-2];

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];   // results waiting downstream, head first
  logic [EW-1:0] fl_q[$];    // issued ops, oldest first
  int            fl_age[$];  // edges since issue, parallel to fl_q
  bit            m_ready_en;
  logic [31:0]   m_a, m_b;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_in_ready();
    return m_ready_en && ((FIFO_DEPTH - fl_q.size() - exp_q.size()) != 0);
  endfunction

  task automatic model_clear();
    exp_q.delete();
    fl_q.delete();
    fl_age.delete();
    m_ready_en = 0;
    m_a = '0;
    m_b = '0;
  endtask

  task automatic check_outputs();
    logic [31:0] d;
    check("in_ready", 64'(in_ready), 64'(m_in_ready()));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check("busy", 64'(busy), 64'((exp_q.size() != 0) || (fl_q.size() != 0)));
    check("mul_a", 64'(mul_a), 64'(m_a));
    check("mul_b", 64'(mul_b), 64'(m_b));
    if (exp_q.size() != 0) begin
      d = exp_q[0][31:0];
      check("out_data", 64'(out_data), 64'(d));
      check("out_tag", 64'(out_tag), 64'(exp_q[0][EW-1:32]));
      check("is_nan", 64'(out_is_nan), 64'(d[30:23] == 8'hFF && d[22:0] != 0));
      check("is_inf", 64'(out_is_inf), 64'(d[30:23] == 8'hFF && d[22:0] == 0));
      check("is_zero", 64'(out_is_zero), 64'(d[30:23] == 8'h00));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One clock cycle: drive inputs, advance the model at the edge, check at negedge.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] t, input bit ordy);
    bit acc, pp;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_tag    = t;
    out_ready = ordy;
    acc = v && m_in_ready();
    pp  = (exp_q.size() != 0) && ordy;
    @(posedge clk);
    if (pp) void'(exp_q.pop_front());
    foreach (fl_age[i]) fl_age[i]++;
    while (fl_q.size() != 0 && fl_age[0] == LATENCY) begin
      exp_q.push_back(fl_q.pop_front());
      void'(fl_age.pop_front());
    end
    if (acc) begin
      fl_q.push_back({t, fp_mul(a, b)});
      fl_age.push_back(0);
      m_a = a;
      m_b = b;
    end
    m_ready_en = 1;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 32'd0, 32'd0, '0, ordy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs();
  endtask

  function automatic logic [31:0] rand_op();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       return {s, 8'hFF, 23'd0};
      1:       return {s, 31'd0};
      2:       return {1'b0, 8'hFF, 23'($urandom_range(1, 100))};
      default: return {s, 8'($urandom_range(100, 154)), 23'($urandom)};
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int k, drops, accs, pops;
    model_clear();
    #12;
    check("por_in_ready", 64'(in_ready), 64'd0);
    check("por_out_valid", 64'(out_valid), 64'd0);
    check("por_busy", 64'(busy), 64'd0);
    do_reset();

    // 1: single op, latency and value
    idle(1'b1);
    step(1'b1, 32'h3FC0_0000, 32'h4000_0000, 4'd3, 1'b0);
    k = 0;
    while (!out_valid && k < 40) begin
      idle(1'b0);
      k++;
    end
    check("t1_latency", 64'(k), 64'(LATENCY));
    check("t1_data", 64'(out_data), 64'h4040_0000);
    check("t1_tag", 64'(out_tag), 64'd3);
    check("t1_flags", 64'({out_is_nan, out_is_inf, out_is_zero}), 64'd0);
    idle(1'b1);

    // 2: 40 back-to-back ops, downstream always ready
    drops = 0;
    for (int i = 0; i < 40; i++) begin
      if (!in_ready) drops++;
      step(1'b1, rand_op(), rand_op(), i[TAG_W-1:0], 1'b1);
    end
    check("t2_in_ready_drops", 64'(drops), 64'd0);
    repeat (LATENCY + 4) idle(1'b1);

    // 3: backpressure fills exactly FIFO_DEPTH credits, then drain
    accs = 0;
    for (int i = 0; i < 30; i++) begin
      if (in_ready) accs++;
      step(1'b1, rand_op(), rand_op(), i[TAG_W-1:0], 1'b0);
    end
    check("t3_accepts", 64'(accs), 64'(FIFO_DEPTH));
    check("t3_in_ready_low", 64'(in_ready), 64'd0);
    pops = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) pops++;
      idle(1'b1);
    end
    check("t3_pops", 64'(pops), 64'(FIFO_DEPTH));

    // 4: special values
    step(1'b1, 32'h7F80_0000, 32'h0000_0000, 4'd5, 1'b0);
    step(1'b1, 32'h7F80_0000, 32'h4000_0000, 4'd6, 1'b0);
    k = 0;
    while (!out_valid && k < 40) begin
      idle(1'b0);
      k++;
    end
    check("t4_nan_data", 64'(out_data), 64'h7FFF_FFFF);
    check("t4_nan_flag", 64'(out_is_nan), 64'd1);
    idle(1'b1);
    check("t4_inf_data", 64'(out_data), 64'h7F80_0000);
    check("t4_inf_flag", 64'(out_is_inf), 64'd1);
    repeat (4) idle(1'b1);

    // 5: full FIFO, then random pops against a steady in_valid
    repeat (LATENCY + FIFO_DEPTH + 4) step(1'b1, rand_op(), rand_op(), 4'd9, 1'b0);
    check("t5_full_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, rand_op(), rand_op(), 4'd10, 1'b1);
    for (int i = 0; i < 60; i++)
      step(1'b1, rand_op(), rand_op(), i[TAG_W-1:0], 1'($urandom_range(0, 1)));

    // Random mixed traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), rand_op(), rand_op(), 4'($urandom),
           ($urandom_range(0, 3) != 0));
    repeat (LATENCY + FIFO_DEPTH + 4) idle(1'b1);

    // 6: reset with 10 ops in flight, no stale results afterwards
    for (int i = 0; i < 10; i++) step(1'b1, rand_op(), rand_op(), i[TAG_W-1:0], 1'b1);
    do_reset();
    repeat (LATENCY + 6) idle(1'b1);
    step(1'b1, 32'h3FC0_0000, 32'h4000_0000, 4'd7, 1'b1);
    repeat (LATENCY + 4) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
